// File: rtl/bcd_convert_arbiter_pkg.sv
// bcd_convert_arbiter_pkg: shared FSM encoding and BCD constants for the converter arbiter
// Contents: BIN_W operand width, BCD_MAX_BIN largest convertible operand,
//           BCD_SAT saturated result for overflow, state_t one-hot FSM states.
package bcd_convert_arbiter_pkg;
    localparam int BIN_W = 12;
    localparam logic [BIN_W-1:0] BCD_MAX_BIN = 12'd999;
    localparam logic [BIN_W-1:0] BCD_SAT = 12'h999;
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LAUNCH = 4'b0010,
        WAIT   = 4'b0100,
        RESP   = 4'b1000
    } state_t;
endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// bcd_convert_arbiter_if: requester and converter handshake bundle of the arbiter
// Requester side: req_valid, req_binary -> req_grant, resp_valid, resp_bcd, resp_ovf, resp_timeout, busy
// Converter side: conv_start, conv_ack, conv_rst, conv_binary -> conv_bcd, conv_done
// master: the environment (requesters + converter); slave: the arbiter.
interface bcd_convert_arbiter_if #(parameter int NUM_REQ = 4);
    import bcd_convert_arbiter_pkg::*;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*BIN_W-1:0] req_binary;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [BIN_W-1:0]         resp_bcd;
    logic                     resp_ovf;
    logic                     resp_timeout;
    logic                     busy;
    logic                     conv_start;
    logic                     conv_ack;
    logic                     conv_rst;
    logic [BIN_W-1:0]         conv_binary;
    logic [BIN_W-1:0]         conv_bcd;
    logic                     conv_done;
    modport master (
        output req_valid, req_binary, conv_bcd, conv_done,
        input  req_grant, resp_valid, resp_bcd, resp_ovf, resp_timeout, busy,
               conv_start, conv_ack, conv_rst, conv_binary
    );
    modport slave (
        input  req_valid, req_binary, conv_bcd, conv_done,
        output req_grant, resp_valid, resp_bcd, resp_ovf, resp_timeout, busy,
               conv_start, conv_ack, conv_rst, conv_binary
    );
endinterface

// File: rtl/bcd_convert_arbiter_rr_pick.sv
// bcd_convert_arbiter_rr_pick: combinational round-robin picker
// Ports: req (request vector), rr (first index to consider) -> idx (winner), found (any request)
module bcd_convert_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);
    // Walk offsets from farthest to nearest so the request closest to rr overwrites the rest.
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDX_W'((int'(rr) + k) % NUM_REQ)]) begin
                idx = IDX_W'((int'(rr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: shares one binary-to-BCD converter among NUM_REQ requesters round-robin
// Ports: clk, reset (async, active-high), bus (slave modport): requests/grants/responses
//        towards the requesters and start/ack/rst/done towards the converter.
module bcd_convert_arbiter
    import bcd_convert_arbiter_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic reset,
    bcd_convert_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    state_t           state;
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] pick_bin;

    bcd_convert_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(bus.req_valid),
        .rr(rr),
        .idx(pick),
        .found(found)
    );

    assign pick_bin = bus.req_binary[int'(pick) * BIN_W +: BIN_W];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr <= '0;
            idx <= '0;
            cnt <= '0;
            bus.req_grant <= '0;
            bus.resp_valid <= '0;
            bus.resp_bcd <= '0;
            bus.resp_ovf <= 1'b0;
            bus.resp_timeout <= 1'b0;
            bus.busy <= 1'b0;
            bus.conv_start <= 1'b0;
            bus.conv_ack <= 1'b0;
            bus.conv_rst <= 1'b0;
            bus.conv_binary <= '0;
        end else begin
            bus.req_grant <= '0;
            bus.resp_valid <= '0;
            bus.conv_start <= 1'b0;
            bus.conv_ack <= 1'b0;
            bus.conv_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        idx <= pick;
                        bus.conv_binary <= pick_bin;
                        bus.req_grant <= onehot(pick);
                        bus.busy <= 1'b1;
                        // Out-of-range operands never reach the converter; answer at once saturated.
                        if (pick_bin > BCD_MAX_BIN) begin
                            bus.resp_valid <= onehot(pick);
                            bus.resp_bcd <= BCD_SAT;
                            bus.resp_ovf <= 1'b1;
                            bus.resp_timeout <= 1'b0;
                            state <= RESP;
                        end else begin
                            bus.conv_start <= 1'b1;
                            state <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Checking done first lets a result arriving on the last allowed cycle win.
                    if (bus.conv_done) begin
                        bus.resp_bcd <= bus.conv_bcd;
                        bus.conv_ack <= 1'b1;
                        bus.resp_ovf <= 1'b0;
                        bus.resp_timeout <= 1'b0;
                        bus.resp_valid <= onehot(idx);
                        state <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        bus.resp_bcd <= '0;
                        bus.resp_ovf <= 1'b0;
                        bus.resp_timeout <= 1'b1;
                        bus.conv_rst <= 1'b1;
                        bus.resp_valid <= onehot(idx);
                        state <= RESP;
                    end
                end
                RESP: begin
                    rr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: randomized self-checking bench with converter stub and round-robin reference model
module tb_bcd_convert_arbiter;
    localparam int NR = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_convert_arbiter_if #(.NUM_REQ(NR)) bus();
    bcd_convert_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [11:0] opq [NR][16];
    int head [NR];
    int tail [NR] = '{default: 0};
    int set_cyc [NR];
    logic [NR-1:0] pv = '0;

    int g_idx [$];
    int g_cyc [$];
    int r_idx [$];
    int r_cyc [$];
    logic [11:0] r_bcd [$];
    logic r_ovf [$];
    logic r_to [$];

    int n_start = 0, n_ack = 0, n_rst = 0, start_cyc = 0, done_cyc = 0;
    int overlap = 0, multi_hot = 0;
    bit hang = 1'b0, inject_done = 1'b0, pend = 1'b0;
    int conv_lat = 27, lat_cnt = 0;
    logic [11:0] conv_op = '0;

    int m_rr = 0;
    int e_idx [64];
    logic [11:0] e_bcd [64];
    logic e_ovf [64];
    int e_n = 0;

    function automatic logic [11:0] ref_bcd(input int v);
        if (v > 999) return 12'h999;
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Expected service order: repeatedly take the first pending requester at or after m_rr.
    function automatic void model_run();
        int h [NR];
        int w;
        int c;
        e_n = 0;
        for (int i = 0; i < NR; i++) h[i] = head[i];
        for (int s = 0; s < 64; s++) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                c = (m_rr + k) % NR;
                if (w < 0 && h[c] < tail[c]) w = c;
            end
            if (w < 0) break;
            e_idx[e_n] = w;
            e_bcd[e_n] = ref_bcd(int'(opq[w][h[w] % 16]));
            e_ovf[e_n] = opq[w][h[w] % 16] > 12'd999;
            e_n++;
            h[w]++;
            m_rr = (w + 1) % NR;
        end
    endfunction

    task automatic push(input int i, input logic [11:0] op);
        opq[i][tail[i] % 16] = op;
        tail[i]++;
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && r_idx.size() < n; k++) @(negedge clk);
        ok = r_idx.size() >= n;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_rr = 0;
        @(negedge clk);
    endtask

    // Environment: monitor, converter stub and requesters, all evaluated 1 time unit after each edge.
    initial begin
        bus.req_valid = '0;
        bus.req_binary = '0;
        bus.conv_done = 1'b0;
        bus.conv_bcd = '0;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            set_cyc[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if ($countones(bus.req_grant) > 1 || $countones(bus.resp_valid) > 1) multi_hot++;
            for (int i = 0; i < NR; i++) begin
                if (bus.req_grant[i]) begin
                    g_idx.push_back(i);
                    g_cyc.push_back(cyc);
                end
                if (bus.resp_valid[i]) begin
                    r_idx.push_back(i);
                    r_cyc.push_back(cyc);
                    r_bcd.push_back(bus.resp_bcd);
                    r_ovf.push_back(bus.resp_ovf);
                    r_to.push_back(bus.resp_timeout);
                end
            end
            if (bus.conv_start) begin
                if (pend) overlap++;
                n_start++;
                start_cyc = cyc;
            end
            if (bus.conv_ack) n_ack++;
            if (bus.conv_rst) n_rst++;
            bus.conv_done = inject_done;
            if (reset || bus.conv_rst) pend = 1'b0;
            else if (pend && !hang) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    pend = 1'b0;
                    bus.conv_done = 1'b1;
                    bus.conv_bcd = ref_bcd(int'(conv_op));
                    done_cyc = cyc;
                end
            end
            if (bus.conv_start) begin
                pend = 1'b1;
                conv_op = bus.conv_binary;
                lat_cnt = conv_lat;
            end
            for (int i = 0; i < NR; i++) begin
                if (reset) head[i] = tail[i];
                if (bus.req_grant[i] && head[i] < tail[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_binary[i*12 +: 12] = opq[i][head[i] % 16];
                    if (!pv[i]) set_cyc[i] = cyc;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            pv = bus.req_valid;
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.req_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", bus.req_grant); end
        checks++; if (bus.resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if ({bus.resp_bcd, bus.resp_ovf, bus.resp_timeout} !== '0) begin errors++; $display("FAIL reset_resp: got %h/%b/%b want 0", bus.resp_bcd, bus.resp_ovf, bus.resp_timeout); end
        checks++; if ({bus.conv_start, bus.conv_ack, bus.conv_rst} !== 3'b000) begin errors++; $display("FAIL reset_conv_ctl: got %b want 000", {bus.conv_start, bus.conv_ack, bus.conv_rst}); end
        checks++; if (bus.conv_binary !== '0) begin errors++; $display("FAIL reset_conv_binary: got %h want 0", bus.conv_binary); end
        reset = 1'b0;
        m_rr = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int gb = g_idx.size();
        int rb = r_idx.size();
        int sb = n_start;
        int ab = n_ack;
        bit ok;
        push(0, 12'd255);
        model_run();
        wait_resp(rb + 1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got %0d responses want %0d", r_idx.size() - rb, 1); end
        else begin
            checks++; if (g_idx[gb] !== 0) begin errors++; $display("FAIL single_grant_idx: got %0d want 0", g_idx[gb]); end
            checks++; if (g_cyc[gb] !== set_cyc[0] + 1) begin errors++; $display("FAIL single_grant_lat: got %0d want %0d", g_cyc[gb], set_cyc[0] + 1); end
            checks++; if (n_start - sb !== 1) begin errors++; $display("FAIL single_starts: got %0d want 1", n_start - sb); end
            checks++; if (start_cyc !== g_cyc[gb]) begin errors++; $display("FAIL single_start_cyc: got %0d want %0d", start_cyc, g_cyc[gb]); end
            checks++; if (r_idx[rb] !== 0) begin errors++; $display("FAIL single_resp_idx: got %0d want 0", r_idx[rb]); end
            checks++; if (r_bcd[rb] !== 12'h255) begin errors++; $display("FAIL single_bcd: got %h want 255", r_bcd[rb]); end
            checks++; if ({r_ovf[rb], r_to[rb]} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {r_ovf[rb], r_to[rb]}); end
            checks++; if (r_cyc[rb] !== done_cyc + 1) begin errors++; $display("FAIL single_resp_lat: got %0d want %0d", r_cyc[rb], done_cyc + 1); end
            checks++; if (n_ack - ab !== 1) begin errors++; $display("FAIL single_acks: got %0d want 1", n_ack - ab); end
            checks++; if (r_idx.size() - rb !== 1) begin errors++; $display("FAIL single_resp_count: got %0d want 1", r_idx.size() - rb); end
        end
    endtask

    task automatic test_all_four();
        int gb, rb;
        bit ok;
        do_reset();
        gb = g_idx.size();
        rb = r_idx.size();
        push(0, 12'd7);
        push(1, 12'd42);
        push(2, 12'd999);
        push(3, 12'd0);
        model_run();
        wait_resp(rb + 4, 600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL all4_timeout: got %0d responses want 4", r_idx.size() - rb); end
        else for (int k = 0; k < 4; k++) begin
            checks++; if (g_idx[gb+k] !== k) begin errors++; $display("FAIL all4_grant_order[%0d]: got %0d want %0d", k, g_idx[gb+k], k); end
            checks++; if (r_idx[rb+k] !== k) begin errors++; $display("FAIL all4_resp_order[%0d]: got %0d want %0d", k, r_idx[rb+k], k); end
            checks++; if (r_bcd[rb+k] !== e_bcd[k]) begin errors++; $display("FAIL all4_bcd[%0d]: got %h want %h", k, r_bcd[rb+k], e_bcd[k]); end
            checks++; if ({r_ovf[rb+k], r_to[rb+k]} !== 2'b00) begin errors++; $display("FAIL all4_flags[%0d]: got %b want 00", k, {r_ovf[rb+k], r_to[rb+k]}); end
        end
    endtask

    task automatic test_ovf();
        int gb = g_idx.size();
        int rb = r_idx.size();
        int sb = n_start;
        bit ok;
        push(1, 12'd1000);
        push(3, 12'd4095);
        model_run();
        wait_resp(rb + 2, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_timeout: got %0d responses want 2", r_idx.size() - rb); end
        else for (int k = 0; k < 2; k++) begin
            checks++; if (r_idx[rb+k] !== e_idx[k]) begin errors++; $display("FAIL ovf_idx[%0d]: got %0d want %0d", k, r_idx[rb+k], e_idx[k]); end
            checks++; if (r_bcd[rb+k] !== 12'h999) begin errors++; $display("FAIL ovf_bcd[%0d]: got %h want 999", k, r_bcd[rb+k]); end
            checks++; if ({r_ovf[rb+k], r_to[rb+k]} !== 2'b10) begin errors++; $display("FAIL ovf_flags[%0d]: got %b want 10", k, {r_ovf[rb+k], r_to[rb+k]}); end
            checks++; if (r_cyc[rb+k] !== g_cyc[gb+k]) begin errors++; $display("FAIL ovf_lat[%0d]: got %0d want %0d", k, r_cyc[rb+k], g_cyc[gb+k]); end
        end
        checks++; if (n_start !== sb) begin errors++; $display("FAIL ovf_no_start: got %0d starts want 0", n_start - sb); end
    endtask

    task automatic test_timeout();
        int rb = r_idx.size();
        int rs = n_rst;
        int ab = n_ack;
        bit ok;
        hang = 1'b1;
        push(0, 12'd500);
        model_run();
        wait_resp(rb + 1, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hang_no_resp: got %0d responses want 1", r_idx.size() - rb); end
        else begin
            checks++; if (r_idx[rb] !== 0) begin errors++; $display("FAIL hang_idx: got %0d want 0", r_idx[rb]); end
            checks++; if ({r_bcd[rb], r_ovf[rb], r_to[rb]} !== {12'h000, 2'b01}) begin errors++; $display("FAIL hang_resp: got %h/%b/%b want 000/0/1", r_bcd[rb], r_ovf[rb], r_to[rb]); end
            checks++; if (r_cyc[rb] !== start_cyc + TO + 1) begin errors++; $display("FAIL hang_lat: got %0d want %0d", r_cyc[rb], start_cyc + TO + 1); end
            checks++; if (n_rst - rs !== 1) begin errors++; $display("FAIL hang_conv_rst: got %0d want 1", n_rst - rs); end
            checks++; if (n_ack !== ab) begin errors++; $display("FAIL hang_ack: got %0d want 0", n_ack - ab); end
        end
        hang = 1'b0;
        rb = r_idx.size();
        push(2, 12'd12);
        model_run();
        wait_resp(rb + 1, 200, ok);
        checks++;
        if (!ok || r_idx[rb] !== 2 || r_bcd[rb] !== 12'h012 || r_to[rb] !== 1'b0)
            begin errors++; $display("FAIL after_hang: got ok=%b resp=%h want idx2 012", ok, ok ? r_bcd[rb] : 12'h0); end
        // Done landing on the final allowed cycle must still win over the timeout.
        conv_lat = TO;
        rb = r_idx.size();
        push(1, 12'd321);
        model_run();
        wait_resp(rb + 1, 300, ok);
        checks++;
        if (!ok || r_bcd[rb] !== 12'h321 || r_to[rb] !== 1'b0)
            begin errors++; $display("FAIL done_at_limit: got ok=%b to=%b bcd=%h want 0/321", ok, ok ? r_to[rb] : 1'b0, ok ? r_bcd[rb] : 12'h0); end
        conv_lat = TO + 1;
        rb = r_idx.size();
        push(3, 12'd77);
        model_run();
        wait_resp(rb + 1, 300, ok);
        checks++;
        if (!ok || r_bcd[rb] !== 12'h000 || r_to[rb] !== 1'b1)
            begin errors++; $display("FAIL done_past_limit: got ok=%b to=%b bcd=%h want 1/000", ok, ok ? r_to[rb] : 1'b0, ok ? r_bcd[rb] : 12'h0); end
        conv_lat = 27;
    endtask

    task automatic test_reset_mid();
        int rb = r_idx.size();
        int sb = n_start;
        int ab;
        push(0, 12'd100);
        for (int k = 0; k < 50 && n_start == sb; k++) @(negedge clk);
        checks++; if (n_start == sb) begin errors++; $display("FAIL rmid_no_start: got 0 starts want 1"); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.req_grant, bus.resp_valid} !== '0) begin errors++; $display("FAIL rmid_ctl: got %b/%b/%b want 0", bus.busy, bus.req_grant, bus.resp_valid); end
        checks++; if ({bus.resp_bcd, bus.resp_ovf, bus.resp_timeout} !== '0) begin errors++; $display("FAIL rmid_resp: got %h/%b/%b want 0", bus.resp_bcd, bus.resp_ovf, bus.resp_timeout); end
        checks++; if ({bus.conv_binary, bus.conv_start, bus.conv_ack, bus.conv_rst} !== '0) begin errors++; $display("FAIL rmid_conv: got %h/%b%b%b want 0", bus.conv_binary, bus.conv_start, bus.conv_ack, bus.conv_rst); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_rr = 0;
        ab = n_ack;
        repeat (2) @(negedge clk);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (r_idx.size() !== rb) begin errors++; $display("FAIL rmid_resp_issued: got %0d want 0", r_idx.size() - rb); end
        checks++; if (n_ack !== ab) begin errors++; $display("FAIL rmid_late_ack: got %0d want 0", n_ack - ab); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_fairness();
        int rb = r_idx.size();
        int want [3] = '{0, 3, 0};
        bit ok;
        push(0, 12'd11);
        push(0, 12'd22);
        push(3, 12'd33);
        model_run();
        wait_resp(rb + 3, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fair_timeout: got %0d responses want 3", r_idx.size() - rb); end
        else for (int k = 0; k < 3; k++) begin
            checks++; if (r_idx[rb+k] !== want[k]) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, r_idx[rb+k], want[k]); end
            checks++; if (r_bcd[rb+k] !== e_bcd[k]) begin errors++; $display("FAIL fair_bcd[%0d]: got %h want %h", k, r_bcd[rb+k], e_bcd[k]); end
        end
    endtask

    task automatic test_random();
        int rb, n, sel;
        logic [11:0] op;
        bit ok;
        for (int r = 0; r < 20; r++) begin
            rb = r_idx.size();
            conv_lat = $urandom_range(40, 1);
            sel = $urandom_range(15, 1);
            for (int i = 0; i < NR; i++) begin
                if (sel[i]) begin
                    n = $urandom_range(2, 1);
                    for (int j = 0; j < n; j++) begin
                        case ($urandom_range(5, 0))
                            0: op = 12'd0;
                            1: op = 12'd999;
                            2: op = 12'd1000;
                            3: op = 12'd4095;
                            4: op = 12'($urandom_range(999, 0));
                            default: op = 12'($urandom_range(4095, 0));
                        endcase
                        push(i, op);
                    end
                end
            end
            model_run();
            wait_resp(rb + e_n, 80 * e_n, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand%0d_timeout: got %0d responses want %0d", r, r_idx.size() - rb, e_n); end
            else for (int k = 0; k < e_n; k++) begin
                checks++;
                if (r_idx[rb+k] !== e_idx[k] || r_bcd[rb+k] !== e_bcd[k] || r_ovf[rb+k] !== e_ovf[k] || r_to[rb+k] !== 1'b0)
                    begin errors++; $display("FAIL rand%0d_resp[%0d]: got idx%0d %h ovf%b to%b want idx%0d %h ovf%b to0", r, k, r_idx[rb+k], r_bcd[rb+k], r_ovf[rb+k], r_to[rb+k], e_idx[k], e_bcd[k], e_ovf[k]); end
            end
        end
        conv_lat = 27;
    endtask

    task automatic test_protocol();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL start_overlap: got %0d want 0", overlap); end
        checks++; if (multi_hot !== 0) begin errors++; $display("FAIL not_onehot: got %0d want 0", multi_hot); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_ovf();
        test_timeout();
        test_reset_mid();
        test_fairness();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
